hc86_bist_ctrl: RTL

HC86_BIST_CTRL -- requirements
Module: hc86_bist_ctrl

---
 rtl/hc86_bist_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hc86_bist_ctrl.sv
// hc86_bist_ctrl
// Exhaustive built-in self test sequencer for a quad 2-input XOR unit.
// Walks all 256 combinations of the two 4-bit operands. Each vector is driven,
// allowed to settle for SETTLE cycles, and then the returned Y is compared
// against A xor B.
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous active-high reset
//   start     begin a full test (ignored while busy)
//   abort     cancel a running test; wins over start
//   a_out     A operand to the XOR unit (vec[7:4])
//   b_out     B operand to the XOR unit (vec[3:0])
//   y_in      Y result from the XOR unit, sampled only in CHECK
//   busy      test in progress (DRIVE, SETTLE, CHECK)
//   done      test completed, held until the next start
//   pass      done with zero mismatching vectors
//   err_cnt   number of mismatching vectors, 0..256
//   fail_vec  sticky per-gate mismatch flags
//
// state  | meaning
// IDLE   | waiting for start, operands zero
// DRIVE  | present current vector, load settle timer
// SETTLE | hold operands while the settle timer runs down to zero
// CHECK  | compare y_in, accumulate errors, advance or finish
// FINISH | results valid, done asserted, waiting for start

module hc86_bist_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [4:1] a_out,
  output logic [4:1] b_out,
  input  logic [4:1] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_cnt,
  output logic [4:1] fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_FINISH
  } state_t;

  // Timer counts SETTLE-1 down to 0, giving exactly SETTLE cycles in SETTLE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [7:0] vec;
  logic [3:0] settle_cnt;
  logic [4:1] mismatch;
  logic       launch;

  // A fresh test may be launched from IDLE or FINISH; abort always wins.
  assign launch   = ((state == S_IDLE) || (state == S_FINISH)) && start && !abort;
  assign mismatch = y_in ^ (vec[7:4] ^ vec[3:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (launch) state_nxt = S_DRIVE;
      S_DRIVE:  state_nxt = abort ? S_IDLE : S_SETTLE;
      S_SETTLE: begin
        if (abort)                  state_nxt = S_IDLE;
        else if (settle_cnt == 4'd0) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (abort)              state_nxt = S_IDLE;
        else if (vec == 8'hff)  state_nxt = S_FINISH;
        else                    state_nxt = S_DRIVE;
      end
      S_FINISH: begin
        if (start && abort) state_nxt = S_IDLE;
        else if (launch)    state_nxt = S_DRIVE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: on abort the partial err_cnt/fail_vec are left untouched,
  // including an abort that lands in CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= 8'd0;
      settle_cnt <= 4'd0;
      err_cnt    <= 9'd0;
      fail_vec   <= 4'b0000;
    end else if (launch) begin
      vec        <= 8'd0;
      err_cnt    <= 9'd0;
      fail_vec   <= 4'b0000;
    end else if (!abort) begin
      case (state)
        S_DRIVE:  settle_cnt <= SETTLE_LOAD;
        S_SETTLE: if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        S_CHECK: begin
          if (mismatch != 4'b0000) err_cnt <= err_cnt + 9'd1;
          fail_vec <= fail_vec | mismatch;
          if (vec != 8'hff) vec <= vec + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    pass  = 1'b0;
    a_out = 4'b0000;
    b_out = 4'b0000;
    case (state)
      S_DRIVE, S_SETTLE, S_CHECK: begin
        busy  = 1'b1;
        a_out = vec[7:4];
        b_out = vec[3:0];
      end
      S_FINISH: begin
        done = 1'b1;
        pass = (err_cnt == 9'd0);
      end
      default: ;
    endcase
  end

endmodule
